key_injector: RTL and testbench
===============================

KEY_INJECTOR -- requirements
Module: key_injector

Interface
REQ-001 Parameter FIFO_DEPTH, 16, character FIFO entries; power of 2, range 2..256.
REQ-002 Parameter HOLD_CYCLES, 2000000, clk_sys cycles between a key-press event and its release event.
REQ-003 Parameter GAP_CYCLES, 2000000, clk_sys cycles after every other event before the next event.
REQ-004 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 char_data  in  8  ASCII character to type.
REQ-007 char_valid  in  1  char_data valid; accepted on an edge where char_valid and char_ready are both 1.
REQ-008 char_ready  out  1  FIFO not full.
REQ-009 abort  in  1  level; flush queue and release held keys.
REQ-010 ps2_key  out  11  [7:0] scancode, [8] extended (always 0), [9] pressed, [10] toggles once per event.
REQ-011 busy  out  1  FIFO non-empty or sequencer not IDLE.
REQ-012 unsupported  out  1  one-cycle pulse when a popped character has no mapping.

Function
REQ-013 The block SHALL buffer accepted characters in a FIFO of FIFO_DEPTH entries, in arrival order; char_ready = not full.
REQ-014 Push and pop on the same edge SHALL both take effect; count unchanged.
REQ-015 An event SHALL be one registered update of ps2_key: new [9:0] and inverted [10] on the same edge; no other ps2_key change occurs.
REQ-016 Sequencer states: IDLE, SHIFT_DN, KEY_DN, KEY_UP, SHIFT_UP, WAIT.
REQ-017 In IDLE with FIFO non-empty, the block SHALL pop one character and decode it on the same edge; the first event is emitted on the following edge.
REQ-018 Unshifted character sequence: key press, wait HOLD_CYCLES, key release, wait GAP_CYCLES, IDLE.
REQ-019 Shifted character sequence: press 0x12 (left shift), wait GAP, key press, wait HOLD, key release, wait GAP, release 0x12, wait GAP, IDLE.
REQ-020 Wait semantics: the next event occurs exactly N edges after the previous event, where N is HOLD_CYCLES or GAP_CYCLES.
REQ-021 Unshifted mapping: A-Z and a-z to the letter scancodes (A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A).
REQ-022 Unshifted mapping, digits: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46.
REQ-023 Unshifted mapping, others: space=29, CR 0x0D=5A, BS 0x08=66, ESC 0x1B=76, ','=41, '.'=49, '/'=4A, ';'=4C, '-'=4E, '='=55, quote 0x27=52.
REQ-024 Shifted mapping: '!'=16, '"'=52, '('=46, ')'=45, '*'=3E, '+'=55, ':'=4C, '<'=41, '>'=49, '?'=4A, '@'=1E, '&'=3D.
REQ-025 An unmapped character SHALL assert unsupported for exactly one cycle on the decode edge, emit no event, and return to IDLE.
REQ-026 While abort=1, the FIFO SHALL be cleared every cycle and char_ready held 0.
REQ-027 Abort with key pressed: emit key release on the next edge, then shift release GAP_CYCLES later if shift is down, then return to IDLE with no further wait.
REQ-028 Abort with only shift down: emit shift release on the next edge, then return to IDLE.
REQ-029 Abort during a post-release wait: return to IDLE on the next edge.
REQ-030 busy SHALL be combinationally derived from the FIFO count and state.

Reset
REQ-031 While reset_n=0 at an edge: ps2_key=11'h000, FIFO empty, state IDLE, wait counter 0, busy=0, unsupported=0.
REQ-032 char_ready=0 while reset_n=0, and 1 from the first edge with reset_n=1.
REQ-033 Reset mid-sequence SHALL emit no release events; the downstream receiver is reset together with this block.

Verification (HOLD_CYCLES=4, GAP_CYCLES=3, FIFO_DEPTH=16)
REQ-034 Push 0x41 at edge N while idle -> ps2_key=0x61C at N+2, 0x01C at N+6, busy=0 at N+9.
REQ-035 Push '?' (0x3F) -> events 0x612, 0x24A (+3), 0x44A (+4), 0x012 (+3), spaced as listed; busy=0 three edges after the last event.
REQ-036 Push 17 characters back-to-back while busy -> char_ready=0 after 16 are held; the 17th is stalled until one pop, and all are typed in order.
REQ-037 Push 0x7E -> unsupported high for one cycle, ps2_key unchanged, busy=0 next cycle.
REQ-038 Assert abort during HOLD of '?' with 3 queued -> next edge key release 0x44A, +3 shift release 0x012, FIFO empty, IDLE.
REQ-039 reset_n=0 during HOLD -> ps2_key=0x000 and busy=0 after the edge; char_ready=1 after release of reset.

Source files
------------

// File: rtl/key_injector.sv
// Types queued ASCII characters as PS/2 scancode events on ps2_key, holding each key
// for HOLD_CYCLES and spacing all other events by GAP_CYCLES, with shift wrapping.
module key_injector #(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 2000000,
  parameter int GAP_CYCLES  = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        abort,
  output logic [10:0] ps2_key,
  output logic        busy,
  output logic        unsupported,
  output logic [2:0]  o_dbg_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXW = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int WW   = $clog2(MAXW + 1);
  localparam logic [WW-1:0] HOLD_LD    = WW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] GAP_LD     = WW'(GAP_CYCLES - 1);
  localparam logic [7:0]    SHIFT_CODE = 8'h12;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_DN, S_KEY_DN, S_KEY_UP, S_SHIFT_UP, S_WAIT
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready_en;
  state_t        r_state;
  logic [WW-1:0] r_wait;
  logic [7:0]    r_code;
  logic          r_shift;
  logic          r_abort_seq;
  logic [10:0]   r_ps2;
  logic          r_unsup;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;
  logic [7:0] w_fold;
  logic       w_map_ok;
  logic       w_map_shift;
  logic [7:0] w_map_code;

  // Handshake: a character transfers on any edge where char_valid and char_ready are both 1.
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign char_ready = r_ready_en & reset_n & ~w_full & ~abort;
  assign w_push     = char_valid & char_ready;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty & ~abort;
  assign w_head     = r_mem[r_rd_ptr];

  assign busy        = ~w_empty | (r_state != S_IDLE);
  assign ps2_key     = r_ps2;
  assign unsupported = r_unsup;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= char_data;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Lower-case letters share the scancode of their upper-case form.
  always_comb begin
    w_fold      = w_head;
    w_map_ok    = 1'b1;
    w_map_shift = 1'b0;
    w_map_code  = 8'h00;
    if (w_head >= 8'h61 && w_head <= 8'h7A) w_fold = w_head & 8'hDF;
    case (w_fold)
      8'h41: w_map_code = 8'h1C;  8'h42: w_map_code = 8'h32;  8'h43: w_map_code = 8'h21;
      8'h44: w_map_code = 8'h23;  8'h45: w_map_code = 8'h24;  8'h46: w_map_code = 8'h2B;
      8'h47: w_map_code = 8'h34;  8'h48: w_map_code = 8'h33;  8'h49: w_map_code = 8'h43;
      8'h4A: w_map_code = 8'h3B;  8'h4B: w_map_code = 8'h42;  8'h4C: w_map_code = 8'h4B;
      8'h4D: w_map_code = 8'h3A;  8'h4E: w_map_code = 8'h31;  8'h4F: w_map_code = 8'h44;
      8'h50: w_map_code = 8'h4D;  8'h51: w_map_code = 8'h15;  8'h52: w_map_code = 8'h2D;
      8'h53: w_map_code = 8'h1B;  8'h54: w_map_code = 8'h2C;  8'h55: w_map_code = 8'h3C;
      8'h56: w_map_code = 8'h2A;  8'h57: w_map_code = 8'h1D;  8'h58: w_map_code = 8'h22;
      8'h59: w_map_code = 8'h35;  8'h5A: w_map_code = 8'h1A;
      8'h30: w_map_code = 8'h45;  8'h31: w_map_code = 8'h16;  8'h32: w_map_code = 8'h1E;
      8'h33: w_map_code = 8'h26;  8'h34: w_map_code = 8'h25;  8'h35: w_map_code = 8'h2E;
      8'h36: w_map_code = 8'h36;  8'h37: w_map_code = 8'h3D;  8'h38: w_map_code = 8'h3E;
      8'h39: w_map_code = 8'h46;
      8'h20: w_map_code = 8'h29;  8'h0D: w_map_code = 8'h5A;  8'h08: w_map_code = 8'h66;
      8'h1B: w_map_code = 8'h76;  8'h2C: w_map_code = 8'h41;  8'h2E: w_map_code = 8'h49;
      8'h2F: w_map_code = 8'h4A;  8'h3B: w_map_code = 8'h4C;  8'h2D: w_map_code = 8'h4E;
      8'h3D: w_map_code = 8'h55;  8'h27: w_map_code = 8'h52;
      8'h21: begin w_map_shift = 1'b1; w_map_code = 8'h16; end
      8'h22: begin w_map_shift = 1'b1; w_map_code = 8'h52; end
      8'h28: begin w_map_shift = 1'b1; w_map_code = 8'h46; end
      8'h29: begin w_map_shift = 1'b1; w_map_code = 8'h45; end
      8'h2A: begin w_map_shift = 1'b1; w_map_code = 8'h3E; end
      8'h2B: begin w_map_shift = 1'b1; w_map_code = 8'h55; end
      8'h3A: begin w_map_shift = 1'b1; w_map_code = 8'h4C; end
      8'h3C: begin w_map_shift = 1'b1; w_map_code = 8'h41; end
      8'h3E: begin w_map_shift = 1'b1; w_map_code = 8'h49; end
      8'h3F: begin w_map_shift = 1'b1; w_map_code = 8'h4A; end
      8'h40: begin w_map_shift = 1'b1; w_map_code = 8'h1E; end
      8'h26: begin w_map_shift = 1'b1; w_map_code = 8'h3D; end
      default: w_map_ok = 1'b0;
    endcase
  end

  // Each wait loads N-1 and the next action fires on the edge the counter is seen at 0.
  // r_abort_seq marks a release sequence started by abort, which skips the final WAIT.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_code      <= 8'h00;
      r_shift     <= 1'b0;
      r_abort_seq <= 1'b0;
      r_ps2       <= 11'h000;
      r_unsup     <= 1'b0;
    end else begin
      r_unsup <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_abort_seq <= 1'b0;
          if (w_pop) begin
            if (!w_map_ok) begin
              r_unsup <= 1'b1;
            end else begin
              r_code  <= w_map_code;
              r_shift <= w_map_shift;
              r_wait  <= '0;
              r_state <= w_map_shift ? S_SHIFT_DN : S_KEY_DN;
            end
          end
        end
        S_SHIFT_DN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_ps2   <= {~r_ps2[10], 1'b1, 1'b0, SHIFT_CODE};
            r_wait  <= GAP_LD;
            r_state <= S_KEY_DN;
          end
        end
        S_KEY_DN: begin
          if (abort) begin
            if (r_shift) r_ps2 <= {~r_ps2[10], 1'b0, 1'b0, SHIFT_CODE};
            r_state <= S_IDLE;
          end else if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            r_ps2   <= {~r_ps2[10], 1'b1, 1'b0, r_code};
            r_wait  <= HOLD_LD;
            r_state <= S_KEY_UP;
          end
        end
        S_KEY_UP: begin
          if (abort || r_wait == '0) begin
            r_ps2  <= {~r_ps2[10], 1'b0, 1'b0, r_code};
            r_wait <= GAP_LD;
            if (r_shift) begin
              r_abort_seq <= abort;
              r_state     <= S_SHIFT_UP;
            end else begin
              r_state <= abort ? S_IDLE : S_WAIT;
            end
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        S_SHIFT_UP: begin
          if ((abort && !r_abort_seq) || r_wait == '0) begin
            r_ps2   <= {~r_ps2[10], 1'b0, 1'b0, SHIFT_CODE};
            r_wait  <= GAP_LD;
            r_state <= (abort || r_abort_seq) ? S_IDLE : S_WAIT;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        S_WAIT: begin
          if (abort || r_wait == '0) r_state <= S_IDLE;
          else                       r_wait  <= r_wait - WW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_injector.sv
// Bench for key_injector: characters are expanded into expected scancode events by a
// table-driven model and compared against every observed change of ps2_key.
module tb_key_injector;
  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;

  localparam logic [7:0] LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] OTHER_CHARS [11] = '{
    8'h20, 8'h0D, 8'h08, 8'h1B, 8'h2C, 8'h2E, 8'h2F, 8'h3B, 8'h2D, 8'h3D, 8'h27};
  localparam logic [7:0] OTHER_CODES [11] = '{
    8'h29, 8'h5A, 8'h66, 8'h76, 8'h41, 8'h49, 8'h4A, 8'h4C, 8'h4E, 8'h55, 8'h52};
  localparam logic [7:0] SHIFT_CHARS [12] = '{
    8'h21, 8'h22, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h3A, 8'h3C, 8'h3E, 8'h3F, 8'h40, 8'h26};
  localparam logic [7:0] SHIFT_CODES [12] = '{
    8'h16, 8'h52, 8'h46, 8'h45, 8'h3E, 8'h55, 8'h4C, 8'h41, 8'h49, 8'h4A, 8'h1E, 8'h3D};

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        abort;
  logic [10:0] ps2_key;
  logic        busy;
  logic        unsupported;
  logic [2:0]  dbg_state;

  key_injector #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .abort(abort), .ps2_key(ps2_key), .busy(busy),
    .unsupported(unsupported), .o_dbg_state(dbg_state));

  // ---------------- clock / reset / monitor ----------------
  always #5 clk_sys = ~clk_sys;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [10:0] obs_val_q[$];
  int          obs_cyc_q[$];
  logic [10:0] exp_q[$];
  int          exp_dt_q[$];
  logic [10:0] prev_key;
  logic        prev_busy;
  int          busy_fall_cyc;
  int          unsup_cnt;
  int          unsup_cyc;
  int          unsup_exp;
  logic [9:0]  map_t [256];
  logic        exp_tog;

  always @(posedge clk_sys) begin
    cyc = cyc + 1;
    #1;
    if (ps2_key !== prev_key) begin
      obs_val_q.push_back(ps2_key);
      obs_cyc_q.push_back(cyc);
    end
    prev_key = ps2_key;
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = busy;
    if (unsupported === 1'b1) begin
      unsup_cnt = unsup_cnt + 1;
      unsup_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  function automatic void init_map();
    for (int i = 0; i < 256; i++) map_t[i] = 10'h000;
    for (int i = 0; i < 26; i++) begin
      map_t[65 + i] = {2'b10, LETTER_CODES[i]};
      map_t[97 + i] = {2'b10, LETTER_CODES[i]};
    end
    for (int i = 0; i < 10; i++) map_t[48 + i] = {2'b10, DIGIT_CODES[i]};
    for (int i = 0; i < 11; i++) map_t[OTHER_CHARS[i]] = {2'b10, OTHER_CODES[i]};
    for (int i = 0; i < 12; i++) map_t[SHIFT_CHARS[i]] = {2'b11, SHIFT_CODES[i]};
  endfunction

  function automatic void model_ev(input logic pressed, input logic [7:0] code, input int dt);
    exp_tog = ~exp_tog;
    exp_q.push_back({exp_tog, pressed, 1'b0, code});
    exp_dt_q.push_back(dt);
  endfunction

  function automatic void model_char(input logic [7:0] c);
    logic [9:0] m;
    m = map_t[c];
    if (!m[9]) begin
      unsup_exp = unsup_exp + 1;
    end else if (m[8]) begin
      model_ev(1'b1, 8'h12, -1);
      model_ev(1'b1, m[7:0], GAP);
      model_ev(1'b0, m[7:0], HOLD);
      model_ev(1'b0, 8'h12, GAP);
    end else begin
      model_ev(1'b1, m[7:0], -1);
      model_ev(1'b0, m[7:0], HOLD);
    end
  endfunction

  function automatic logic [7:0] rand_char();
    int k;
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 127));
      1: begin k = $urandom_range(0, 25); return 8'(($urandom_range(0, 1) != 0 ? 97 : 65) + k); end
      2: return SHIFT_CHARS[$urandom_range(0, 11)];
      default: begin
        if ($urandom_range(0, 1) != 0) return 8'(48 + $urandom_range(0, 9));
        return OTHER_CHARS[$urandom_range(0, 10)];
      end
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_all();
    obs_val_q.delete(); obs_cyc_q.delete();
    exp_q.delete(); exp_dt_q.delete();
    busy_fall_cyc = -1; unsup_cnt = 0; unsup_cyc = -1; unsup_exp = 0;
  endtask

  // Leaves char_valid high so consecutive calls push on consecutive edges.
  task automatic push_char(input logic [7:0] c, output int acc_cyc);
    int t;
    @(negedge clk_sys);
    char_data = c; char_valid = 1'b1;
    t = 0;
    while (!char_ready && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    acc_cyc = cyc + 1;
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: char %02h not accepted in 500 cycles", c);
    end
    @(posedge clk_sys);
  endtask

  task automatic idle_inputs();
    @(negedge clk_sys);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk_sys);
      if (busy === 1'b0) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_events(input int n, output bit timed_out);
    timed_out = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk_sys);
      if (obs_val_q.size() >= n) begin timed_out = 1'b0; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; char_valid = 1'b0; char_data = 8'h00; abort = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_vec++; if (ps2_key !== 11'h000) begin n_err++; $display("FAIL rst_ps2: got %03h need 000", ps2_key); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_vec++; if (unsupported !== 1'b0) begin n_err++; $display("FAIL rst_unsup: got %b need 0", unsupported); end
    n_vec++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b need 0", char_ready); end
    reset_n = 1'b1;
    @(negedge clk_sys);
    n_vec++; if (char_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b need 1", char_ready); end
    exp_tog = 1'b0;
    clear_all();
  endtask

  task automatic test_single();
    int n; bit to;
    clear_all();
    push_char(8'h41, n);
    idle_inputs();
    model_char(8'h41);
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL single_idle: busy never fell, need 0"); end
    n_vec++;
    if (obs_val_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_count: got %0d events need %0d", obs_val_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
      n_vec++;
      if (obs_val_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL single_ev%0d: got %03h need %03h", i, obs_val_q[i], exp_q[i]);
      end
    end
    if (obs_cyc_q.size() >= 2) begin
      n_vec++; if (obs_cyc_q[0] !== n + 2) begin n_err++; $display("FAIL single_press_t: got %0d need %0d", obs_cyc_q[0], n + 2); end
      n_vec++; if (obs_cyc_q[1] !== n + 6) begin n_err++; $display("FAIL single_rel_t: got %0d need %0d", obs_cyc_q[1], n + 6); end
    end
    n_vec++; if (busy_fall_cyc !== n + 9) begin n_err++; $display("FAIL single_busy_t: got %0d need %0d", busy_fall_cyc, n + 9); end
  endtask

  task automatic test_shifted();
    int n; bit to; int last;
    clear_all();
    push_char(8'h3F, n);
    idle_inputs();
    model_char(8'h3F);
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL shift_idle: busy never fell, need 0"); end
    n_vec++;
    if (obs_val_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL shift_count: got %0d events need %0d", obs_val_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
      n_vec++;
      if (obs_val_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL shift_ev%0d: got %03h need %03h", i, obs_val_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_cyc_q[i] - obs_cyc_q[i-1] !== exp_dt_q[i]) begin
          n_err++; $display("FAIL shift_dt%0d: got %0d need %0d", i, obs_cyc_q[i] - obs_cyc_q[i-1], exp_dt_q[i]);
        end
      end
    end
    if (obs_cyc_q.size() >= 1) begin
      last = obs_cyc_q[obs_cyc_q.size() - 1];
      n_vec++; if (obs_cyc_q[0] !== n + 2) begin n_err++; $display("FAIL shift_first_t: got %0d need %0d", obs_cyc_q[0], n + 2); end
      n_vec++; if (busy_fall_cyc !== last + GAP) begin n_err++; $display("FAIL shift_busy_t: got %0d need %0d", busy_fall_cyc, last + GAP); end
    end
  endtask

  task automatic test_unsupported();
    int n; bit to;
    clear_all();
    push_char(8'h7E, n);
    idle_inputs();
    model_char(8'h7E);
    wait_idle(to);
    repeat (3) @(negedge clk_sys);
    n_vec++; if (to) begin n_err++; $display("FAIL unsup_idle: busy never fell, need 0"); end
    n_vec++; if (unsup_cnt !== unsup_exp) begin n_err++; $display("FAIL unsup_cnt: got %0d cycles need %0d", unsup_cnt, unsup_exp); end
    n_vec++; if (unsup_cyc !== n + 1) begin n_err++; $display("FAIL unsup_t: got %0d need %0d", unsup_cyc, n + 1); end
    n_vec++; if (obs_val_q.size() != 0) begin n_err++; $display("FAIL unsup_noevent: got %0d events need 0", obs_val_q.size()); end
    n_vec++; if (busy_fall_cyc !== n + 1) begin n_err++; $display("FAIL unsup_busy_t: got %0d need %0d", busy_fall_cyc, n + 1); end
  endtask

  task automatic test_back_to_back();
    int n0; int acc; bit to; logic [7:0] c;
    clear_all();
    c = 8'(65 + $urandom_range(0, 25));
    push_char(c, n0);
    model_char(c);
    for (int k = 0; k < 17; k++) begin
      c = 8'(($urandom_range(0, 1) != 0 ? 97 : 65) + $urandom_range(0, 25));
      push_char(c, acc);
      model_char(c);
    end
    n_vec++; if (acc !== n0 + 17) begin n_err++; $display("FAIL b2b_nostall: got accept %0d need %0d", acc, n0 + 17); end
    @(negedge clk_sys);
    n_vec++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got ready %b need 0", char_ready); end
    c = 8'(48 + $urandom_range(0, 9));
    push_char(c, acc);
    model_char(c);
    idle_inputs();
    n_vec++; if (acc !== n0 + 20) begin n_err++; $display("FAIL b2b_stall: got accept %0d need %0d", acc, n0 + 20); end
    for (int i = 2; i < exp_dt_q.size(); i += 2) exp_dt_q[i] = GAP + 2;
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL b2b_idle: busy never fell, need 0"); end
    n_vec++;
    if (obs_val_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d events need %0d", obs_val_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
      n_vec++;
      if (obs_val_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_ev%0d: got %03h need %03h", i, obs_val_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_cyc_q[i] - obs_cyc_q[i-1] !== exp_dt_q[i]) begin
          n_err++; $display("FAIL b2b_dt%0d: got %0d need %0d", i, obs_cyc_q[i] - obs_cyc_q[i-1], exp_dt_q[i]);
        end
      end
    end
  endtask

  task automatic test_random(input int rounds);
    int acc; bit to; logic [7:0] c;
    for (int r = 0; r < rounds; r++) begin
      clear_all();
      for (int k = 0; k < 12; k++) begin
        c = rand_char();
        push_char(c, acc);
        model_char(c);
      end
      idle_inputs();
      wait_idle(to);
      n_vec++; if (to) begin n_err++; $display("FAIL rand%0d_idle: busy never fell, need 0", r); end
      n_vec++; if (unsup_cnt !== unsup_exp) begin n_err++; $display("FAIL rand%0d_unsup: got %0d need %0d", r, unsup_cnt, unsup_exp); end
      n_vec++;
      if (obs_val_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d events need %0d", r, obs_val_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
        n_vec++;
        if (obs_val_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_ev%0d: got %03h need %03h", r, i, obs_val_q[i], exp_q[i]);
        end
        if (i > 0 && exp_dt_q[i] >= 0) begin
          n_vec++;
          if (obs_cyc_q[i] - obs_cyc_q[i-1] !== exp_dt_q[i]) begin
            n_err++; $display("FAIL rand%0d_dt%0d: got %0d need %0d", r, i, obs_cyc_q[i] - obs_cyc_q[i-1], exp_dt_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_abort_hold();
    int acc; bit to;
    clear_all();
    push_char(8'h3F, acc);
    push_char(8'h41, acc);
    push_char(8'h42, acc);
    push_char(8'h43, acc);
    idle_inputs();
    model_char(8'h3F);
    exp_dt_q[2] = 1;
    wait_events(2, to);
    n_vec++; if (to) begin n_err++; $display("FAIL abh_press: key press not seen"); end
    abort = 1'b1;
    @(negedge clk_sys);
    n_vec++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL abh_ready: got %b need 0", char_ready); end
    @(negedge clk_sys);
    abort = 1'b0;
    wait_idle(to);
    repeat (10) @(negedge clk_sys);
    n_vec++; if (to) begin n_err++; $display("FAIL abh_idle: busy never fell, need 0"); end
    n_vec++;
    if (obs_val_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL abh_count: got %0d events need %0d", obs_val_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
      n_vec++;
      if (obs_val_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL abh_ev%0d: got %03h need %03h", i, obs_val_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_cyc_q[i] - obs_cyc_q[i-1] !== exp_dt_q[i]) begin
          n_err++; $display("FAIL abh_dt%0d: got %0d need %0d", i, obs_cyc_q[i] - obs_cyc_q[i-1], exp_dt_q[i]);
        end
      end
    end
    if (obs_cyc_q.size() >= 4) begin
      n_vec++;
      if (busy_fall_cyc !== obs_cyc_q[3]) begin
        n_err++; $display("FAIL abh_busy_t: got %0d need %0d", busy_fall_cyc, obs_cyc_q[3]);
      end
    end
  endtask

  task automatic test_abort_shift();
    int acc; bit to;
    clear_all();
    push_char(8'h2B, acc);
    idle_inputs();
    model_ev(1'b1, 8'h12, -1);
    model_ev(1'b0, 8'h12, 1);
    wait_events(1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL abs_press: shift press not seen"); end
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    wait_idle(to);
    repeat (10) @(negedge clk_sys);
    n_vec++;
    if (obs_val_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL abs_count: got %0d events need %0d", obs_val_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_val_q.size(); i++) begin
      n_vec++;
      if (obs_val_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL abs_ev%0d: got %03h need %03h", i, obs_val_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_cyc_q[i] - obs_cyc_q[i-1] !== exp_dt_q[i]) begin
          n_err++; $display("FAIL abs_dt%0d: got %0d need %0d", i, obs_cyc_q[i] - obs_cyc_q[i-1], exp_dt_q[i]);
        end
      end
    end
    if (obs_cyc_q.size() >= 2) begin
      n_vec++;
      if (busy_fall_cyc !== obs_cyc_q[1]) begin
        n_err++; $display("FAIL abs_busy_t: got %0d need %0d", busy_fall_cyc, obs_cyc_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc; bit to;
    clear_all();
    push_char(8'h5A, acc);
    idle_inputs();
    wait_events(1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL rmid_press: key press not seen"); end
    reset_n = 1'b0;
    @(negedge clk_sys);
    n_vec++; if (ps2_key !== 11'h000) begin n_err++; $display("FAIL rmid_ps2: got %03h need 000", ps2_key); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b need 0", busy); end
    n_vec++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b need 0", char_ready); end
    reset_n = 1'b1;
    @(negedge clk_sys);
    n_vec++; if (char_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready_after: got %b need 1", char_ready); end
    repeat (10) @(negedge clk_sys);
    n_vec++; if (ps2_key !== 11'h000) begin n_err++; $display("FAIL rmid_norelease: got %03h need 000", ps2_key); end
    exp_tog = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    init_map();
    exp_tog = 1'b0;
    clear_all();
    test_reset();
    test_single();
    test_shifted();
    test_unsupported();
    test_back_to_back();
    test_random(3);
    test_abort_hold();
    test_abort_shift();
    test_single();
    test_reset_mid();
    test_shifted();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
